// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router synchronizer.
// Address codes, timeout defaults and the address decode helper.
package router_pkg;

  localparam logic [1:0] ADDR_P0 = 2'b00;
  localparam logic [1:0] ADDR_P1 = 2'b01;
  localparam logic [1:0] ADDR_P2 = 2'b10;

  localparam int SYNC_TIMEOUT = 30;
  localparam int SYNC_CNT_W   = 5;

  function automatic logic [2:0] addr_onehot(
    input logic [1:0] a
  );
    logic [2:0] oh;
    oh = 3'b000;
    unique case (1'b1)
      (a == ADDR_P0): oh = 3'b001;
      (a == ADDR_P1): oh = 3'b010;
      (a == ADDR_P2): oh = 3'b100;
      default:        oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/sync_timeout_ctr.sv
// Idle-port watchdog: pulses srst for one cycle every TIMEOUT idle cycles.
// Ports: clk, rst (async active-low), vld, re in; srst out.
module sync_timeout_ctr
  import router_pkg::*;
#(
  parameter int TIMEOUT = SYNC_TIMEOUT,
  parameter int CNT_W   = SYNC_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic re,
  output logic srst
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             idle;

  assign idle = vld & ~re;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      srst <= 1'b0;
    end else if (idle) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        srst <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        srst <= 1'b0;
      end
    end else begin
      cnt  <= '0;
      srst <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync.sv
// Router synchronizer: address latch, FIFO write steering, full/valid
// status and per-port idle soft reset. Ports: clk, rst (async active-low),
// detect_add, wr_en_reg, din[1:0], e0..2, f0..2, re0..2 in;
// we[2:0], fifofull, srst0..2, vldout0..2 out.
// Macro SYNC_SOFT_RESET_EN builds the soft-reset counters; else srst=0.
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = SYNC_TIMEOUT,
  parameter int CNT_W   = SYNC_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       detect_add,
  input  logic       wr_en_reg,
  input  logic [1:0] din,
  input  logic       e0,
  input  logic       e1,
  input  logic       e2,
  input  logic       f0,
  input  logic       f1,
  input  logic       f2,
  input  logic       re0,
  input  logic       re1,
  input  logic       re2,
  output logic [2:0] we,
  output logic       fifofull,
  output logic       srst0,
  output logic       srst1,
  output logic       srst2,
  output logic       vldout0,
  output logic       vldout1,
  output logic       vldout2
);

  logic [1:0] addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= ADDR_P0;
    end else if (detect_add) begin
      addr <= din;
    end
  end

  always_comb begin
    we = wr_en_reg ? addr_onehot(addr) : 3'b000;
  end

  always_comb begin
    fifofull = 1'b0;
    unique case (1'b1)
      (addr == ADDR_P0): fifofull = f0;
      (addr == ADDR_P1): fifofull = f1;
      (addr == ADDR_P2): fifofull = f2;
      default:           fifofull = 1'b0;
    endcase
  end

  assign vldout0 = ~e0;
  assign vldout1 = ~e1;
  assign vldout2 = ~e2;

`ifdef SYNC_SOFT_RESET_EN
  sync_timeout_ctr #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_ctr0 (
    .clk (clk),
    .rst (rst),
    .vld (vldout0),
    .re  (re0),
    .srst(srst0)
  );

  sync_timeout_ctr #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_ctr1 (
    .clk (clk),
    .rst (rst),
    .vld (vldout1),
    .re  (re1),
    .srst(srst1)
  );

  sync_timeout_ctr #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_ctr2 (
    .clk (clk),
    .rst (rst),
    .vld (vldout2),
    .re  (re2),
    .srst(srst2)
  );
`else
  logic re_unused;
  assign re_unused = ^{re0, re1, re2};
  assign srst0 = 1'b0;
  assign srst1 = 1'b0;
  assign srst2 = 1'b0;
`endif

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync with an expected-value queue.
// Soft-reset expectations follow SYNC_SOFT_RESET_EN.
module tb_router_sync;
  import router_pkg::*;

  localparam int T = SYNC_TIMEOUT;

  typedef struct packed {
    logic [2:0] we;
    logic       ff;
    logic [2:0] srst;
    logic [2:0] vld;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       detect_add;
  logic       wr_en_reg;
  logic [1:0] din;
  logic       e0, e1, e2;
  logic       f0, f1, f2;
  logic       re0, re1, re2;
  logic [2:0] we;
  logic       fifofull;
  logic       srst0, srst1, srst2;
  logic       vldout0, vldout1, vldout2;

  int ncmp = 0;
  int nerr = 0;

  exp_t       q[$];
  logic [1:0] m_addr;
  int         run[3];

  router_sync dut (
    .clk       (clk),
    .rst       (rst),
    .detect_add(detect_add),
    .wr_en_reg (wr_en_reg),
    .din       (din),
    .e0        (e0),
    .e1        (e1),
    .e2        (e2),
    .f0        (f0),
    .f1        (f1),
    .f2        (f2),
    .re0       (re0),
    .re1       (re1),
    .re2       (re2),
    .we        (we),
    .fifofull  (fifofull),
    .srst0     (srst0),
    .srst1     (srst1),
    .srst2     (srst2),
    .vldout0   (vldout0),
    .vldout1   (vldout1),
    .vldout2   (vldout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] dec(input logic [1:0] a);
    logic [2:0] r;
    case (a)
      2'b00:   r = 3'b001;
      2'b01:   r = 3'b010;
      2'b10:   r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // Predict the state after the coming edge, queue it, then compare.
  task automatic step(input string tag);
    exp_t       x;
    exp_t       y;
    logic [2:0] ev;
    logic [2:0] rv;
    logic [2:0] sv;
    ev = {e2, e1, e0};
    rv = {re2, re1, re0};
    if (detect_add) m_addr = din;
    for (int i = 0; i < 3; i++) begin
      if (!ev[i] && !rv[i]) run[i] = run[i] + 1;
      else run[i] = 0;
`ifdef SYNC_SOFT_RESET_EN
      x.srst[i] = (run[i] > 0) && (run[i] % T == 0);
`else
      x.srst[i] = 1'b0;
`endif
    end
    x.we = wr_en_reg ? dec(m_addr) : 3'b000;
    case (m_addr)
      2'b00:   x.ff = f0;
      2'b01:   x.ff = f1;
      2'b10:   x.ff = f2;
      default: x.ff = 1'b0;
    endcase
    x.vld = ~ev;
    q.push_back(x);
    @(posedge clk);
    #1;
    y = q.pop_front();
    sv = {srst2, srst1, srst0};
    chk({tag, " we"}, {5'd0, we}, {5'd0, y.we});
    chk({tag, " fifofull"}, {7'd0, fifofull}, {7'd0, y.ff});
    chk({tag, " srst"}, {5'd0, sv}, {5'd0, y.srst});
    chk({tag, " vldout"},
        {5'd0, vldout2, vldout1, vldout0}, {5'd0, y.vld});
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #2;
    m_addr = 2'b00;
    for (int i = 0; i < 3; i++) run[i] = 0;
    chk({tag, " rst srst"}, {5'd0, srst2, srst1, srst0}, 8'd0);
    chk({tag, " rst we"}, {5'd0, we},
        {5'd0, (wr_en_reg ? 3'b001 : 3'b000)});
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    detect_add = 1'b0;
    wr_en_reg = 1'b0;
    din = 2'b00;
    {e0, e1, e2} = 3'b000;
    {f0, f1, f2} = 3'b000;
    {re0, re1, re2} = 3'b000;
    m_addr = 2'b00;
    for (int i = 0; i < 3; i++) run[i] = 0;

    // 1: reset state
    #12;
    chk("t1 we", {5'd0, we}, 8'd0);
    chk("t1 fifofull", {7'd0, fifofull}, 8'd0);
    chk("t1 srst", {5'd0, srst2, srst1, srst0}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    step("t1a");
    step("t1b");
    {e0, e1, e2} = 3'b111;
    step("t1c");

    // 2: address 01 steering
    din = 2'b01;
    detect_add = 1'b1;
    wr_en_reg = 1'b1;
    step("t2 we");
    detect_add = 1'b0;
    f1 = 1'b1;
    step("t2 full");
    wr_en_reg = 1'b0;
    step("t2 wroff");
    f1 = 1'b0;

    // 3: port 1 idle timeout, then drained
    e1 = 1'b0;
    re1 = 1'b0;
    for (int i = 0; i < 35; i++) step("t3 idle");
    re1 = 1'b1;
    for (int i = 0; i < 3; i++) step("t3 read");
    e1 = 1'b1;
    re1 = 1'b0;

    // 4: invalid address, then port 2
    din = 2'b11;
    detect_add = 1'b1;
    wr_en_reg = 1'b1;
    f0 = 1'b1;
    step("t4 bad");
    detect_add = 1'b0;
    step("t4 bad hold");
    din = 2'b10;
    detect_add = 1'b1;
    step("t4 p2");
    detect_add = 1'b0;
    f2 = 1'b1;
    step("t4 p2 full");
    f0 = 1'b0;
    f2 = 1'b0;

    // 5: reset mid-count, then read pulse mid-count
    e1 = 1'b0;
    for (int i = 0; i < 20; i++) step("t5 pre");
    f0 = 1'b1;
    do_reset("t5");
    step("t5 addr0 full");
    f0 = 1'b0;
    for (int i = 0; i < 34; i++) step("t5 post");
    for (int i = 0; i < 15; i++) step("t5 mid");
    re1 = 1'b1;
    step("t5 re");
    re1 = 1'b0;
    for (int i = 0; i < 32; i++) step("t5 restart");
    e1 = 1'b1;
    step("t5 done");

    // 6: ports 0 and 2 time out together
    wr_en_reg = 1'b0;
    e0 = 1'b0;
    e2 = 1'b0;
    for (int i = 0; i < 32; i++) step("t6 both");
    {e0, e1, e2} = 3'b111;
    step("t6 end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
